// File: rtl/task_dispatcher.sv
// task_dispatcher: two-task round-robin owner of a shared resource.
// Exactly one of grant_acq/grant_txd is high after reset. The owner hands the
// resource to the other task by raising its done level, and the handover takes
// effect at that same clock edge. The done input of the task that does not
// hold the grant is ignored.
// Optional build macro: TASK_DISPATCHER_TIMEOUT_EN adds a watchdog. With it,
// an owner that never raises done loses the grant after TIMEOUT_CYCLES cycles.
module task_dispatcher #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned FIRST_TASK     = 0
) (
  input  logic clk,
  input  logic rst,
  output logic grant_acq,
  output logic grant_txd,
  input  logic done_acq,
  input  logic done_txd
);

  typedef enum logic {
    S_ACQ = 1'b0,
    S_TXD = 1'b1
  } state_e;

  localparam state_e RST_STATE = (FIRST_TASK != 0) ? S_TXD : S_ACQ;

  // Reject a watchdog limit outside 2..65535 at elaboration time.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("task_dispatcher: TIMEOUT_CYCLES must be in 2..65535");
  end

  state_e state_q, state_d;
  logic   owner_done;
  logic   handover;

  // Only the current owner's done counts; the other task's done is ignored.
  assign owner_done = (state_q == S_ACQ) ? done_acq : done_txd;

`ifdef TASK_DISPATCHER_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        expired;

  // The count starts at 0 on the first cycle of each ownership.
  // Reaching CNT_LAST therefore ends an ownership of exactly
  // TIMEOUT_CYCLES cycles.
  assign expired  = (cnt_q == CNT_LAST);
  assign handover = owner_done || expired;

  // Cycle counter: it clears on a handover and counts up otherwise.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (handover) begin
      cnt_d = 16'd0;
    end
  end

  // Watchdog counter register. Reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign handover = owner_done;
`endif

  // Next-state logic: move to the other task on a handover, otherwise hold.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ACQ:   if (handover) state_d = S_TXD;
      S_TXD:   if (handover) state_d = S_ACQ;
      default: state_d = RST_STATE;
    endcase
  end

  // State register. Reset wins over done and over the watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // The grants decode only the state flop, so done has no direct path to them.
  assign grant_acq = (state_q == S_ACQ);
  assign grant_txd = (state_q == S_TXD);

endmodule

// File: tb/tb_task_dispatcher.sv
// tb_task_dispatcher: directed test of task_dispatcher.
// Two instances share all inputs: u_dut starts with acquisition, and u_dut1
// starts with transmit. The grants are compared as the pair
// {grant_acq, grant_txd}: 2'b10 means acquisition owns the resource and
// 2'b01 means transmit owns it.
// When the bench is built with TASK_DISPATCHER_TIMEOUT_EN, the watchdog
// section runs with TIMEOUT_CYCLES=8. Without the macro, a 100-cycle hold
// runs instead.
module tb_task_dispatcher;

  localparam logic [1:0] G_ACQ = 2'b10;
  localparam logic [1:0] G_TXD = 2'b01;

  logic clk;
  logic rst;
  logic done_acq;
  logic done_txd;
  logic grant_acq, grant_txd;
  logic grant_acq1, grant_txd1;

  int checks;
  int failures;

  task_dispatcher #(.TIMEOUT_CYCLES(8), .FIRST_TASK(0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .grant_acq (grant_acq),
    .grant_txd (grant_txd),
    .done_acq  (done_acq),
    .done_txd  (done_txd)
  );

  task_dispatcher #(.TIMEOUT_CYCLES(8), .FIRST_TASK(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .grant_acq (grant_acq1),
    .grant_txd (grant_txd1),
    .done_acq  (done_acq),
    .done_txd  (done_txd)
  );

  // Clock generation: 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Wait for one rising edge, then let the outputs settle.
  // Checks and new input values both happen at this point, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [1:0] got,
                          input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    done_acq = 1'b0;
    done_txd = 1'b0;

    // Reset: acquisition owns first in u_dut, transmit owns first in u_dut1.
    tick();
    check_eq("reset_acq_first", {grant_acq, grant_txd}, G_ACQ);
    check_eq("reset_txd_first", {grant_acq1, grant_txd1}, G_TXD);
    rst = 1'b0;

    // Idle cycles with no done: the grant stays with acquisition.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("idle_hold", {grant_acq, grant_txd}, G_ACQ);
    end

    // ACQ to TXD: done_acq at one edge moves the grant at that edge.
    done_acq = 1'b1;
    tick();
    check_eq("acq_to_txd", {grant_acq, grant_txd}, G_TXD);
    done_acq = 1'b0;
    tick();
    check_eq("txd_hold", {grant_acq, grant_txd}, G_TXD);

    // Four round trips. Every sampled cycle must have exactly one grant.
    for (int r = 0; r < 4; r++) begin
      done_txd = 1'b1;
      tick();
      check_eq("rt_txd_to_acq", {grant_acq, grant_txd}, G_ACQ);
      done_txd = 1'b0;
      done_acq = 1'b1;
      tick();
      check_eq("rt_acq_to_txd", {grant_acq, grant_txd}, G_TXD);
      done_acq = 1'b0;
    end
    done_txd = 1'b1;
    tick();
    check_eq("back_to_acq", {grant_acq, grant_txd}, G_ACQ);
    done_txd = 1'b0;

    // A done from the task without the grant changes nothing.
    done_txd = 1'b1;
    tick();
    check_eq("non_owner_done", {grant_acq, grant_txd}, G_ACQ);
    done_txd = 1'b0;
    tick();
    check_eq("non_owner_after", {grant_acq, grant_txd}, G_ACQ);

    // Both done inputs pulsed together: only the owner's done takes effect.
    done_acq = 1'b1;
    done_txd = 1'b1;
    tick();
    check_eq("both_pulse", {grant_acq, grant_txd}, G_TXD);
    done_acq = 1'b0;
    done_txd = 1'b0;
    tick();
    check_eq("both_pulse_after", {grant_acq, grant_txd}, G_TXD);

    // Both done inputs held for 6 cycles, starting from TXD:
    // the grant alternates ACQ, TXD, ACQ, and so on.
    done_acq = 1'b1;
    done_txd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("both_held_alt", {grant_acq, grant_txd},
               (i % 2 == 0) ? G_ACQ : G_TXD);
    end
    done_acq = 1'b0;
    done_txd = 1'b0;
    tick();
    check_eq("both_held_end", {grant_acq, grant_txd}, G_TXD);

    // done_txd held across a handover: once transmit has handed over,
    // its held done must not trigger a second handover.
    done_txd = 1'b1;
    tick();
    check_eq("held_handover", {grant_acq, grant_txd}, G_ACQ);
    tick();
    check_eq("held_no_second", {grant_acq, grant_txd}, G_ACQ);
    tick();
    check_eq("held_no_third", {grant_acq, grant_txd}, G_ACQ);
    done_txd = 1'b0;

    // Reset in S_TXD together with done_txd: reset wins and forces S_ACQ.
    done_acq = 1'b1;
    tick();
    check_eq("pre_rst_txd", {grant_acq, grant_txd}, G_TXD);
    done_acq = 1'b0;
    rst      = 1'b1;
    done_txd = 1'b1;
    tick();
    check_eq("rst_mid_txd", {grant_acq, grant_txd}, G_ACQ);
    check_eq("rst_mid_first1", {grant_acq1, grant_txd1}, G_TXD);
    done_txd = 1'b0;

    // Reset in S_ACQ together with done_acq: reset wins and S_ACQ stays.
    done_acq = 1'b1;
    tick();
    check_eq("rst_over_done_acq", {grant_acq, grant_txd}, G_ACQ);
    done_acq = 1'b0;
    rst      = 1'b0;
    tick();
    check_eq("post_rst_hold", {grant_acq, grant_txd}, G_ACQ);

`ifdef TASK_DISPATCHER_TIMEOUT_EN
    // Watchdog with no done: each ownership lasts 8 cycles.
    // Reset leaves the counter at 0. After k edges the grant is ACQ when
    // (k/8) is even and TXD when it is odd.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      check_eq("wdog_toggle", {grant_acq, grant_txd},
               ((k / 8) % 2 == 0) ? G_ACQ : G_TXD);
    end

    // done_acq on the 5th cycle hands over at that edge and clears the counter.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    check_eq("wdog_pre_done", {grant_acq, grant_txd}, G_ACQ);
    done_acq = 1'b1;
    tick();
    check_eq("wdog_done_c5", {grant_acq, grant_txd}, G_TXD);
    done_acq = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    check_eq("wdog_txd_full7", {grant_acq, grant_txd}, G_TXD);
    tick();
    check_eq("wdog_txd_expire", {grant_acq, grant_txd}, G_ACQ);
`else
    // No watchdog: with no done, acquisition keeps the grant for 100 cycles.
    for (int k = 0; k < 100; k++) begin
      tick();
      check_eq("no_wdog_hold", {grant_acq, grant_txd}, G_ACQ);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
